// File: rtl/riscv_wb_q.sv
// riscv_wb_q - RISC-V writeback queue.
//
// Holds up to DEPTH in-flight MEM results (ALU pass-through and loads) in
// program order, pairs in-order data-bus responses with outstanding loads,
// extracts and extends load data for XLEN 32/64, and retires at most one
// register-file write per cycle in program order. An empty queue lets an
// entry that is already complete flow straight through to the write port.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   mem_wb_valid     MEM offers an entry; accepted when mem_wb_rdy is high
//   mem_wb_rdy       queue has room (registered count < DEPTH)
//   mem_wb_funct     load function (0 = ALU result, 1..7 = LB..LD)
//   mem_wb_data      ALU result or load byte address
//   mem_wb_rsd       destination register
//   data_bif_rdata   load response data, XLEN-aligned
//   data_bif_rvalid  one response per pulse, in issue order
//   wb_rf_data       register-file write data
//   wb_rf_rsd        register-file write register
//   wb_rf_write      one-cycle write strobe
//   wb_pend          occupied entries
//   wb_err           one-cycle error pulse (stray response or illegal load)
module riscv_wb_q #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FUNCT_W = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       mem_wb_valid,
    output logic                       mem_wb_rdy,
    input  logic [FUNCT_W-1:0]         mem_wb_funct,
    input  logic [XLEN-1:0]            mem_wb_data,
    input  logic [4:0]                 mem_wb_rsd,
    input  logic [XLEN-1:0]            data_bif_rdata,
    input  logic                       data_bif_rvalid,
    output logic [XLEN-1:0]            wb_rf_data,
    output logic [4:0]                 wb_rf_rsd,
    output logic                       wb_rf_write,
    output logic [$clog2(DEPTH+1)-1:0] wb_pend,
    output logic                       wb_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(XLEN / 8);

    localparam logic [FUNCT_W-1:0] F_NOP = FUNCT_W'(0);
    localparam logic [FUNCT_W-1:0] F_LB  = FUNCT_W'(1);
    localparam logic [FUNCT_W-1:0] F_LH  = FUNCT_W'(2);
    localparam logic [FUNCT_W-1:0] F_LW  = FUNCT_W'(3);
    localparam logic [FUNCT_W-1:0] F_LBU = FUNCT_W'(4);
    localparam logic [FUNCT_W-1:0] F_LHU = FUNCT_W'(5);
    localparam logic [FUNCT_W-1:0] F_LWU = FUNCT_W'(6);
    localparam logic [FUNCT_W-1:0] F_LD  = FUNCT_W'(7);

    // Queue storage
    logic [FUNCT_W-1:0] q_funct [DEPTH];
    logic [XLEN-1:0]    q_data  [DEPTH];
    logic [4:0]         q_rsd   [DEPTH];
    logic [XLEN-1:0]    q_rdata [DEPTH];
    logic [DEPTH-1:0]   q_done;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    // Control
    logic          match_found;
    logic [PW-1:0] match_idx;
    logic [PW-1:0] scan_idx;
    logic          in_nop;
    logic          accept;
    logic          flow;
    logic          push;
    logic          head_done;
    logic          head_direct;
    logic          pop;
    logic          resp_to_q;
    logic          resp_to_new;
    logic          resp_to_flow;
    logic          resp_drop;

    // Retire selection
    logic               ret_valid;
    logic [FUNCT_W-1:0] ret_funct;
    logic [XLEN-1:0]    ret_addr;
    logic [XLEN-1:0]    ret_rdata;
    logic [4:0]         ret_rsd;
    logic [XLEN-1:0]    ret_val;
    logic               ret_err;

    // Widened to 64 bits so one body covers both XLEN values; the result is
    // truncated back to XLEN. For XLEN=32, LWU/LD fall back to LW and flag.
    function automatic logic [XLEN:0] extract(
        input logic [FUNCT_W-1:0] funct,
        input logic [XLEN-1:0]    addr,
        input logic [XLEN-1:0]    rdata
    );
        logic [XLEN-1:0] sh;
        logic [63:0]     sh64;
        logic [63:0]     res;
        logic            illegal;
        sh      = rdata >> {addr[BW-1:0], 3'b000};
        sh64    = 64'(sh);
        illegal = 1'b0;
        case (funct)
            F_LB:  res = {{56{sh64[7]}},  sh64[7:0]};
            F_LH:  res = {{48{sh64[15]}}, sh64[15:0]};
            F_LW:  res = {{32{sh64[31]}}, sh64[31:0]};
            F_LBU: res = {56'd0, sh64[7:0]};
            F_LHU: res = {48'd0, sh64[15:0]};
            F_LWU: begin
                if (XLEN == 32) begin
                    res     = {{32{sh64[31]}}, sh64[31:0]};
                    illegal = 1'b1;
                end else begin
                    res = {32'd0, sh64[31:0]};
                end
            end
            F_LD: begin
                if (XLEN == 32) begin
                    res     = {{32{sh64[31]}}, sh64[31:0]};
                    illegal = 1'b1;
                end else begin
                    res = sh64;
                end
            end
            default: res = 64'(addr);
        endcase
        return {illegal, res[XLEN-1:0]};
    endfunction

    assign mem_wb_rdy = (count < CW'(DEPTH));
    assign wb_pend    = count;

    // Oldest occupied entry still waiting for its response
    always_comb begin
        match_found = 1'b0;
        match_idx   = rd_ptr;
        scan_idx    = rd_ptr;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (!match_found && (CW'(i) < count) && !q_done[scan_idx] &&
                (q_funct[scan_idx] != F_NOP)) begin
                match_found = 1'b1;
                match_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        in_nop      = (mem_wb_funct == F_NOP);
        accept      = mem_wb_valid && mem_wb_rdy;
        flow        = accept && (count == '0) && (in_nop || data_bif_rvalid);
        push        = accept && !flow;
        head_done   = (count != '0) && q_done[rd_ptr];
        // The scan starts at the head, so an undone head is always the target
        head_direct = (count != '0) && !q_done[rd_ptr] && data_bif_rvalid &&
                      match_found && (match_idx == rd_ptr);
        pop         = head_done || head_direct;

        resp_to_q    = data_bif_rvalid && match_found;
        resp_to_new  = data_bif_rvalid && !match_found && push && !in_nop;
        resp_to_flow = data_bif_rvalid && flow && !in_nop;
        resp_drop    = data_bif_rvalid && !resp_to_q && !resp_to_new && !resp_to_flow;
    end

    always_comb begin
        ret_valid = pop || flow;
        ret_funct = mem_wb_funct;
        ret_addr  = mem_wb_data;
        ret_rdata = data_bif_rdata;
        ret_rsd   = mem_wb_rsd;
        if (pop) begin
            ret_funct = q_funct[rd_ptr];
            ret_addr  = q_data[rd_ptr];
            ret_rsd   = q_rsd[rd_ptr];
            ret_rdata = head_done ? q_rdata[rd_ptr] : data_bif_rdata;
        end
        {ret_err, ret_val} = extract(ret_funct, ret_addr, ret_rdata);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_funct[i] <= '0;
                q_data[i]  <= '0;
                q_rsd[i]   <= '0;
                q_rdata[i] <= '0;
            end
            q_done      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wb_rf_data  <= '0;
            wb_rf_rsd   <= '0;
            wb_rf_write <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            if (push) begin
                q_funct[wr_ptr] <= mem_wb_funct;
                q_data[wr_ptr]  <= mem_wb_data;
                q_rsd[wr_ptr]   <= mem_wb_rsd;
                q_rdata[wr_ptr] <= resp_to_new ? data_bif_rdata : '0;
                q_done[wr_ptr]  <= in_nop || resp_to_new;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (resp_to_q) begin
                q_rdata[match_idx] <= data_bif_rdata;
                q_done[match_idx]  <= 1'b1;
            end
            // Placed after the response write so a direct retire leaves the slot clean
            if (pop) begin
                q_done[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            wb_rf_write <= ret_valid && (ret_rsd != 5'd0);
            wb_rf_data  <= (ret_valid && (ret_rsd != 5'd0)) ? ret_val : '0;
            wb_rf_rsd   <= ret_valid ? ret_rsd : 5'd0;
            wb_err      <= resp_drop || (ret_valid && ret_err);
        end
    end

endmodule

// File: tb/tb_riscv_wb_q.sv
// tb_riscv_wb_q - self-checking bench for riscv_wb_q.
// Instance u_a is XLEN=32, u_b is XLEN=64, both DEPTH=4. A vector table covers
// single-cycle extraction; hand-written sequences cover queueing corner cases.
module tb_riscv_wb_q;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid, a_rdy, a_rvalid, a_write, a_err;
    logic [2:0]  a_funct, a_pend;
    logic [31:0] a_data, a_rdata, a_wdata;
    logic [4:0]  a_rsd, a_wrsd;

    logic        b_valid, b_rdy, b_rvalid, b_write, b_err;
    logic [2:0]  b_funct, b_pend;
    logic [63:0] b_data, b_rdata, b_wdata;
    logic [4:0]  b_rsd, b_wrsd;

    riscv_wb_q #(.XLEN(32), .DEPTH(4), .FUNCT_W(3)) u_a (
        .clk(clk), .rstn(rstn),
        .mem_wb_valid(a_valid), .mem_wb_rdy(a_rdy), .mem_wb_funct(a_funct),
        .mem_wb_data(a_data), .mem_wb_rsd(a_rsd),
        .data_bif_rdata(a_rdata), .data_bif_rvalid(a_rvalid),
        .wb_rf_data(a_wdata), .wb_rf_rsd(a_wrsd), .wb_rf_write(a_write),
        .wb_pend(a_pend), .wb_err(a_err)
    );

    riscv_wb_q #(.XLEN(64), .DEPTH(4), .FUNCT_W(3)) u_b (
        .clk(clk), .rstn(rstn),
        .mem_wb_valid(b_valid), .mem_wb_rdy(b_rdy), .mem_wb_funct(b_funct),
        .mem_wb_data(b_data), .mem_wb_rsd(b_rsd),
        .data_bif_rdata(b_rdata), .data_bif_rvalid(b_rvalid),
        .wb_rf_data(b_wdata), .wb_rf_rsd(b_wrsd), .wb_rf_write(b_write),
        .wb_pend(b_pend), .wb_err(b_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is64;
        logic [2:0]  funct;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic        rvalid;
        logic [4:0]  rsd;
        logic [63:0] exp_data;
        logic        exp_write;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_funct = 3'd0; a_data = '0; a_rsd = '0; a_rdata = '0; a_rvalid = 1'b0;
        b_valid = 1'b0; b_funct = 3'd0; b_data = '0; b_rsd = '0; b_rdata = '0; b_rvalid = 1'b0;
    endtask

    task automatic push_a(input logic [2:0] f, input logic [31:0] d, input logic [4:0] r);
        a_valid = 1'b1; a_funct = f; a_data = d; a_rsd = r;
    endtask

    task automatic check_a(input string name, input logic w, input logic [4:0] r,
                           input logic [31:0] d, input logic [2:0] p);
        check({name, "_write"}, 64'(a_write), 64'(w));
        check({name, "_rsd"},   64'(a_wrsd),  64'(r));
        check({name, "_data"},  64'(a_wdata), 64'(d));
        check({name, "_pend"},  64'(a_pend),  64'(p));
    endtask

    initial begin
        //            is64  funct addr    rdata                    rv    rsd    exp_data                 wr    err
        vecs[0]  = '{1'b0, 3'd1, 64'h3, 64'h80FF_0000,           1'b1, 5'd1,  64'hFFFF_FF80,           1'b1, 1'b0}; // LB
        vecs[1]  = '{1'b0, 3'd4, 64'h3, 64'h80FF_0000,           1'b1, 5'd2,  64'h0000_0080,           1'b1, 1'b0}; // LBU
        vecs[2]  = '{1'b0, 3'd2, 64'h2, 64'h80FF_0000,           1'b1, 5'd3,  64'hFFFF_80FF,           1'b1, 1'b0}; // LH
        vecs[3]  = '{1'b0, 3'd5, 64'h2, 64'h80FF_0000,           1'b1, 5'd4,  64'h0000_80FF,           1'b1, 1'b0}; // LHU
        vecs[4]  = '{1'b0, 3'd3, 64'h0, 64'h8000_0001,           1'b1, 5'd5,  64'h8000_0001,           1'b1, 1'b0}; // LW
        vecs[5]  = '{1'b0, 3'd1, 64'h0, 64'h1234_5678,           1'b1, 5'd6,  64'h0000_0078,           1'b1, 1'b0}; // LB +
        vecs[6]  = '{1'b0, 3'd1, 64'h1, 64'h0000_8000,           1'b1, 5'd7,  64'hFFFF_FF80,           1'b1, 1'b0}; // LB off 1
        vecs[7]  = '{1'b0, 3'd6, 64'h0, 64'hCAFE_BABE,           1'b1, 5'd8,  64'hCAFE_BABE,           1'b1, 1'b1}; // LWU illegal
        vecs[8]  = '{1'b0, 3'd7, 64'h0, 64'hCAFE_BABE,           1'b1, 5'd9,  64'hCAFE_BABE,           1'b1, 1'b1}; // LD illegal
        vecs[9]  = '{1'b0, 3'd0, 64'h1234, 64'h0,                1'b0, 5'd5,  64'h0000_1234,           1'b1, 1'b0}; // NOP
        vecs[10] = '{1'b0, 3'd0, 64'h55, 64'h0,                  1'b0, 5'd0,  64'h0,                   1'b0, 1'b0}; // NOP x0
        vecs[11] = '{1'b1, 3'd7, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'd10, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0}; // LD
        vecs[12] = '{1'b1, 3'd6, 64'h4, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'd11, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0}; // LWU
        vecs[13] = '{1'b1, 3'd3, 64'h4, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'd12, 64'hFFFF_FFFF_DEAD_BEEF, 1'b1, 1'b0}; // LW
        vecs[14] = '{1'b1, 3'd1, 64'h7, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'd13, 64'hFFFF_FFFF_FFFF_FFDE, 1'b1, 1'b0}; // LB
        vecs[15] = '{1'b1, 3'd5, 64'h6, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'd14, 64'h0000_0000_0000_DEAD, 1'b1, 1'b0}; // LHU

        idle();
        step();
        step();
        rstn = 1'b1;

        // Reset state
        check_a("reset", 1'b0, 5'd0, 32'd0, 3'd0);
        check("reset_err", 64'(a_err), 64'd0);
        check("reset_rdy", 64'(a_rdy), 64'd1);
        check("reset_b_pend", 64'(b_pend), 64'd0);
        step();

        // Flow-through extraction table
        for (int i = 0; i < 16; i++) begin
            logic [63:0] w_data;
            logic [4:0]  w_rsd;
            logic        w_write, w_err;
            if (vecs[i].is64) begin
                b_valid = 1'b1; b_funct = vecs[i].funct; b_data = vecs[i].addr;
                b_rsd = vecs[i].rsd; b_rvalid = vecs[i].rvalid; b_rdata = vecs[i].rdata;
            end else begin
                a_valid = 1'b1; a_funct = vecs[i].funct; a_data = vecs[i].addr[31:0];
                a_rsd = vecs[i].rsd; a_rvalid = vecs[i].rvalid; a_rdata = vecs[i].rdata[31:0];
            end
            step();
            idle();
            w_data  = vecs[i].is64 ? b_wdata : 64'(a_wdata);
            w_rsd   = vecs[i].is64 ? b_wrsd  : a_wrsd;
            w_write = vecs[i].is64 ? b_write : a_write;
            w_err   = vecs[i].is64 ? b_err   : a_err;
            check($sformatf("vec%0d_data", i),  w_data,      vecs[i].exp_data);
            check($sformatf("vec%0d_write", i), 64'(w_write), 64'(vecs[i].exp_write));
            check($sformatf("vec%0d_rsd", i),   64'(w_rsd),  vecs[i].exp_write ? 64'(vecs[i].rsd) : 64'd0);
            check($sformatf("vec%0d_err", i),   64'(w_err),  64'(vecs[i].exp_err));
            step();
            check($sformatf("vec%0d_after", i), vecs[i].is64 ? 64'(b_write) : 64'(a_write), 64'd0);
        end

        // Queued LB, response two cycles later, retired straight from the bus
        push_a(3'd1, 32'h3, 5'd3);
        step(); idle();
        check_a("lbq_push", 1'b0, 5'd0, 32'd0, 3'd1);
        step();
        check_a("lbq_wait", 1'b0, 5'd0, 32'd0, 3'd1);
        a_rvalid = 1'b1; a_rdata = 32'h80FF_0000;
        step(); idle();
        check_a("lbq_ret", 1'b1, 5'd3, 32'hFFFF_FF80, 3'd0);
        step();
        check_a("lbq_idle", 1'b0, 5'd0, 32'd0, 3'd0);

        // ALU result waits behind an outstanding load
        push_a(3'd3, 32'h0, 5'd1);
        step();
        push_a(3'd0, 32'd7, 5'd2);
        step(); idle();
        check_a("ord_pend2", 1'b0, 5'd0, 32'd0, 3'd2);
        step();
        check_a("ord_hold", 1'b0, 5'd0, 32'd0, 3'd2);
        a_rvalid = 1'b1; a_rdata = 32'h11;
        step(); idle();
        check_a("ord_load", 1'b1, 5'd1, 32'h11, 3'd1);
        step();
        check_a("ord_nop", 1'b1, 5'd2, 32'd7, 3'd0);
        step();
        check_a("ord_idle", 1'b0, 5'd0, 32'd0, 3'd0);

        // Fill to DEPTH, offered entry refused, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            push_a(3'd3, 32'h0, 5'(10 + i));
            step();
        end
        push_a(3'd0, 32'h99, 5'd20);
        check("full_rdy", 64'(a_rdy), 64'd0);
        check("full_pend", 64'(a_pend), 64'd4);
        step(); idle();
        check("full_refused_pend", 64'(a_pend), 64'd4);
        check("full_refused_write", 64'(a_write), 64'd0);
        for (int i = 0; i < 4; i++) begin
            a_rvalid = 1'b1; a_rdata = 32'h100 + 32'(i);
            step();
            check_a($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i), 3'(3 - i));
            if (i == 0) check("drain_rdy", 64'(a_rdy), 64'd1);
        end
        idle();
        step();
        check_a("drain_idle", 1'b0, 5'd0, 32'd0, 3'd0);

        // Simultaneous push and pop keep the count
        push_a(3'd3, 32'h0, 5'd6);
        step();
        push_a(3'd0, 32'h77, 5'd7);
        a_rvalid = 1'b1; a_rdata = 32'h42;
        step(); idle();
        check_a("pp_load", 1'b1, 5'd6, 32'h42, 3'd1);
        step();
        check_a("pp_nop", 1'b1, 5'd7, 32'h77, 3'd0);
        step();

        // Response lands in a load pushed the same cycle behind a completed NOP
        push_a(3'd3, 32'h0, 5'd8);
        step();
        push_a(3'd0, 32'h99, 5'd9);
        step(); idle();
        a_rvalid = 1'b1; a_rdata = 32'h88;
        step(); idle();
        check_a("new_l1", 1'b1, 5'd8, 32'h88, 3'd1);
        push_a(3'd3, 32'h0, 5'd11);
        a_rvalid = 1'b1; a_rdata = 32'hAB;
        step(); idle();
        check_a("new_nop", 1'b1, 5'd9, 32'h99, 3'd1);
        check("new_err", 64'(a_err), 64'd0);
        step();
        check_a("new_l2", 1'b1, 5'd11, 32'hAB, 3'd0);
        step();

        // Stray response with an empty queue
        a_rvalid = 1'b1; a_rdata = 32'h5;
        step(); idle();
        check("stray_err", 64'(a_err), 64'd1);
        check("stray_write", 64'(a_write), 64'd0);
        step();
        check("stray_err_clr", 64'(a_err), 64'd0);

        // Reset with three entries in flight
        for (int i = 0; i < 3; i++) begin
            push_a(3'd3, 32'h0, 5'(20 + i));
            step();
        end
        idle();
        check("rst_pre_pend", 64'(a_pend), 64'd3);
        #2 rstn = 1'b0;
        #1;
        check_a("rst_mid", 1'b0, 5'd0, 32'd0, 3'd0);
        check("rst_mid_err", 64'(a_err), 64'd0);
        step();
        rstn = 1'b1;
        step();
        check_a("rst_after", 1'b0, 5'd0, 32'd0, 3'd0);
        check("rst_after_rdy", 64'(a_rdy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_wb_q.md
# riscv_wb_q

Parametrised writeback stage for the RISC-V core. It sits between the MEM stage and the register file. It tracks up to DEPTH in-flight MEM results (ALU pass-through and loads) in program order, matches in-order data-bus responses to outstanding loads, and performs byte/half/word/double extraction with sign or zero extension for XLEN 32 or 64. It retires at most one register-file write per cycle, never out of order, with a flow-through path for an empty queue.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- DEPTH, 4, in-flight entries; power of 2, ≥2.
- FUNCT_W, 3, load function width; encoding: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- mem_wb_valid  in  1  MEM offers an entry.
- mem_wb_rdy  out  1  entry accepted when valid&&rdy.
- mem_wb_funct  in  FUNCT_W  load function; NOP = ALU result.
- mem_wb_data  in  XLEN  ALU result (NOP) or load byte address.
- mem_wb_rsd  in  5  destination register.
- data_bif_rdata  in  XLEN  load response data, XLEN-aligned.
- data_bif_rvalid  in  1  one response per pulse, in issue order.
- wb_rf_data  out  XLEN  write data.
- wb_rf_rsd  out  5  write register.
- wb_rf_write  out  1  one-cycle write strobe.
- wb_pend  out  $clog2(DEPTH+1)  occupied entries.
- wb_err  out  1  one-cycle error pulse.

## Operation
- Queue: circular buffer; rd/wr pointers $clog2(DEPTH) bits wrap naturally; count register. Each entry holds funct, data/address, rsd, rdata, done flag.
- mem_wb_rdy = (count < DEPTH); combinational from count only.
- Push on valid&&rdy unless flow-through. NOP entries are pushed done=1. Load entries are pushed done=0.
- Response matching: rvalid writes rdata into the oldest entry with done=0, funct≠NOP, and sets done. If no such entry exists but a load is pushed the same cycle, the response goes into that new entry. Otherwise the response is dropped and wb_err pulses.
- Retire, at most one per cycle:
  - If the queue is non-empty and the head has done=1, pop the head.
  - If the head is a load with done=0, rvalid is high, and the head is the match target, retire it directly from data_bif_rdata without waiting a cycle.
  - Flow-through: if the queue is empty and valid&&rdy, the input retires without a push. This applies when the input is a NOP, or a load with rvalid high in the same cycle.
- Extraction: boff = addr[$clog2(XLEN/8)-1:0]; sh = rdata >> (8*boff).
  - LB/LBU use sh[7:0]; LH/LHU use sh[15:0]; LW/LWU use sh[31:0]; LD uses sh[63:0]. Each is extended to XLEN, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU.
  - For XLEN=32, LW = sh. LWU and LD are illegal: the entry retires as LW and wb_err pulses at retire.
- Retire registers: data, rsd, write=1. When rsd==0, write=0 and data=0, but the entry is still consumed. When nothing retires, all three are cleared to 0.

## Timing
- Reset: wb_rf_data=0, wb_rf_rsd=0, wb_rf_write=0, wb_err=0, wb_pend=0, pointers=0, all done flags=0. Reset mid-operation discards every entry. Responses still outstanding after reset are the bus owner's responsibility.
- Flow-through latency: input accepted in cycle N, wb_rf_write high in N+1.
- Queued NOP: retires the cycle it reaches head with done=1; strobe the following cycle.
- Load: strobe in the cycle after the later of rvalid or reaching head.
- Simultaneous push and pop are allowed when count<DEPTH; count is unchanged.
- Full (count==DEPTH): rdy=0; a pop that cycle does not raise rdy until the next cycle.
- An ALU result behind an outstanding load waits; it is never reordered.
- wb_pend reflects the registered count.

## Test plan
- Empty queue, NOP data=0x1234 rsd=5 in cycle 0 -> cycle 1: write=1, rsd=5, data=0x1234; next cycle write=0.
- XLEN=32: LB addr=0x3, then rvalid rdata=0x80FF_0000 two cycles later -> data=0xFFFF_FF80. LBU with the same stimulus -> 0x0000_0080. LH addr=0x2 -> 0xFFFF_80FF.
- Load rsd=1, then NOP rsd=2 data=7, rvalid 3 cycles later with rdata=0x11 -> rsd1=0x11 is written first, then rsd2=7 the next cycle; wb_pend peaks at 2.
- DEPTH=4: push 4 loads with no responses -> rdy=0, wb_pend=4. Then 4 rvalids back-to-back -> 4 consecutive strobes; rdy returns high the cycle after the first pop.
- XLEN=64: LD addr=0 rdata=0xDEAD_BEEF_0123_4567 -> full value. LWU addr=4 -> 0x0000_0000_DEAD_BEEF. LW addr=4 -> 0xFFFF_FFFF_DEAD_BEEF.
- rvalid with an empty queue -> wb_err pulse, no write. NOP with rsd=0 -> write=0. Reset asserted with 3 entries -> all outputs 0, wb_pend=0.
